// File: rtl/sine_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : sine_seq_if
//  Purpose  : Control, configuration and sample-output bundle of the sine
//             sequencer. The master side drives requests/config and accepts
//             samples; the slave side is the sequencer itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface sine_seq_if #(
    parameter int ACC_W = 16,
    parameter int DIV_W = 8
);
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_step;
    logic [DIV_W-1:0] cfg_div;
    logic [5:0]       lut_addr;
    logic             sign;
    logic [1:0]       quadrant;
    logic             out_valid;
    logic             out_ready;
    logic             wrap;
    logic             busy;

    modport master (
        output start, stop, cfg_valid, cfg_step, cfg_div, out_ready,
        input  cfg_ready, lut_addr, sign, quadrant, out_valid, wrap, busy
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_step, cfg_div, out_ready,
        output cfg_ready, lut_addr, sign, quadrant, out_valid, wrap, busy
    );
endinterface
`default_nettype wire

// File: rtl/sine_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sine_sequencer
//  Purpose  : Phase-accumulator controller for a 64-entry quarter-wave sine
//             LUT. Produces mirrored LUT address, sign and quadrant per
//             sample at a programmable step and rate, hands samples out over
//             valid/ready and stops cleanly.
//  Options  : SINE_SEQ_STOP_ZC_EN - when defined, stop finishes the current
//             period (ends on the sample whose phase addition carries out);
//             when undefined, stop ends ticking at once and drains.
//  Revision : 1.0 - initial release
// ============================================================================
module sine_sequencer #(
    parameter int ACC_W = 16,   // must be >= 8
    parameter int DIV_W = 8
) (
    input  wire       clk,
    input  wire       rst,
    sine_seq_if.slave bus
);
    localparam logic [1:0] C_IDLE     = 2'd0;
    localparam logic [1:0] C_RUN      = 2'd1;
    localparam logic [1:0] C_STOPPING = 2'd2;
    localparam logic [1:0] C_DRAIN    = 2'd3;

`ifdef SINE_SEQ_STOP_ZC_EN
    localparam logic [1:0] C_STOP_TGT = C_STOPPING;
`else
    localparam logic [1:0] C_STOP_TGT = C_DRAIN;
`endif

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] phase_q, phase_d;
    logic [ACC_W-1:0] step_q,  step_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic [5:0]       addr_q,  addr_d;
    logic             sign_q,  sign_d;
    logic [1:0]       quad_q,  quad_d;
    logic             valid_q, valid_d;
    logic             wrap_q,  wrap_d;
    logic             busy_q;
    logic             cfg_ready_q;

    logic             active_w;
    logic             tick_w;
    logic             cfg_xfer_w;
    logic [ACC_W:0]   sum_w;
    logic [1:0]       quad_w;
    logic [5:0]       idx_w;

    // A tick is never allowed to overwrite a sample that is still waiting,
    // so a stalled output simply holds the counter at its terminal value.
    assign active_w   = (state_q == C_RUN) || (state_q == C_STOPPING);
    assign tick_w     = active_w && (cnt_q == div_q) && !(valid_q && !bus.out_ready);
    assign cfg_xfer_w = bus.cfg_valid && cfg_ready_q;
    assign sum_w      = {1'b0, phase_q} + {1'b0, step_q};
    assign quad_w     = phase_q[ACC_W-1:ACC_W-2];
    assign idx_w      = phase_q[ACC_W-3:ACC_W-8];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= C_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:     if (bus.start) state_d = C_RUN;
            C_RUN:      if (bus.stop)  state_d = C_STOP_TGT;
            C_STOPPING: if ((step_q == '0) || (tick_w && sum_w[ACC_W])) state_d = C_DRAIN;
            C_DRAIN:    if (!valid_q || bus.out_ready) state_d = C_IDLE;
            default:    state_d = C_IDLE;
        endcase
    end

    // Datapath / output next values; later assignments take priority
    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sign_d  = sign_q;
        quad_d  = quad_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (valid_q && bus.out_ready) valid_d = 1'b0;

        if (tick_w) begin
            addr_d  = quad_w[0] ? ~idx_w : idx_w;
            sign_d  = quad_w[1];
            quad_d  = quad_w;
            valid_d = 1'b1;
            phase_d = sum_w[ACC_W-1:0];
            wrap_d  = sum_w[ACC_W];
            cnt_d   = '0;
        end else if (active_w && (cnt_q != div_q)) begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // The tick above already consumed the old step/div this cycle.
        if (cfg_xfer_w) begin
            step_d = bus.cfg_step;
            div_d  = bus.cfg_div;
            cnt_d  = '0;
        end

        if ((state_q == C_IDLE) && bus.start) begin
            phase_d = '0;
            cnt_d   = '0;
        end

        if ((state_q == C_DRAIN) && (state_d == C_IDLE)) phase_d = '0;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            step_q      <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            sign_q      <= 1'b0;
            quad_q      <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            phase_q     <= phase_d;
            step_q      <= step_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sign_q      <= sign_d;
            quad_q      <= quad_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            busy_q      <= (state_d != C_IDLE);
            cfg_ready_q <= (state_d == C_IDLE) || (state_d == C_RUN);
        end
    end

    assign bus.lut_addr  = addr_q;
    assign bus.sign      = sign_q;
    assign bus.quadrant  = quad_q;
    assign bus.out_valid = valid_q;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_ready = cfg_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sine_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sine_sequencer
//  Purpose  : Self-checking bench for sine_sequencer. A reference phase
//             model fills a scoreboard of expected samples; each scenario
//             task pops and compares as samples are accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sine_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sine_seq_if #(.ACC_W(16), .DIV_W(8)) bus ();

    sine_sequencer #(.ACC_W(16), .DIV_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef SINE_SEQ_STOP_ZC_EN
    localparam int STOP_DIV = 0, STOP_AT = 100, STOP_TOTAL = 256, STEP0_TOTAL = 5;
`else
    localparam int STOP_DIV = 3, STOP_AT = 5,   STOP_TOTAL = 5,   STEP0_TOTAL = 4;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  sb[$];          // {wrap, quadrant, sign, lut_addr}
    logic [15:0] m_phase;
    logic [15:0] m_step;
    logic [9:0]  obs_v;
    logic [9:0]  exp_v;

    assign obs_v = {bus.wrap, bus.quadrant, bus.sign, bus.lut_addr};

    task automatic tick_obs();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected samples from the bench's own phase counter.
    task automatic push_samples(input int n);
        int unsigned t;
        logic [1:0]  q;
        logic [5:0]  idx;
        logic [5:0]  a;
        for (int i = 0; i < n; i++) begin
            q   = m_phase[15:14];
            idx = m_phase[13:8];
            a   = q[0] ? (6'd63 - idx) : idx;
            t   = int'(m_phase) + int'(m_step);
            sb.push_back({(t >= 65536), q, (q >= 2'd2), a});
            m_phase = t[15:0];
        end
    endtask

    task automatic do_reset();
        bus.start = 0; bus.stop = 0; bus.cfg_valid = 0;
        bus.cfg_step = 0; bus.cfg_div = 0; bus.out_ready = 1;
        rst = 1;
        tick_obs(); tick_obs();
        rst = 0;
        tick_obs();
        sb.delete();
        m_phase = 0;
    endtask

    task automatic configure(input logic [15:0] st, input logic [7:0] dv);
        bus.cfg_valid = 1; bus.cfg_step = st; bus.cfg_div = dv;
        tick_obs();
        bus.cfg_valid = 0;
        m_step = st;
    endtask

    task automatic start_run();
        bus.start = 1;
        tick_obs();
        bus.start = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.lut_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", bus.lut_addr); end
        checks++; if (bus.sign !== 1'b0) begin errors++; $display("FAIL reset_sign: got %b, expected 0", bus.sign); end
        checks++; if (bus.quadrant !== 2'd0) begin errors++; $display("FAIL reset_quadrant: got %0d, expected 0", bus.quadrant); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.out_valid); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b, expected 0", bus.wrap); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b, expected 1", bus.cfg_ready); end
    endtask

    task automatic test_basic();
        int got = 0;
        int first = -1;
        do_reset();
        configure(16'h0100, 8'd0);
        push_samples(300);
        start_run();
        for (int cyc = 0; cyc < 320 && got < 300; cyc++) begin
            tick_obs();
            if (bus.out_valid) begin
                if (first < 0) first = cyc;
                exp_v = sb.pop_front();
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL basic_sample[%0d]: got %h, expected %h", got, obs_v, exp_v); end
                got++;
            end else if (got > 0) begin
                checks++; errors++;
                $display("FAIL basic_gap: got out_valid 0 at cycle %0d, expected 1", cyc);
            end
        end
        checks++; if (first != 0) begin errors++; $display("FAIL basic_latency: got cycle %0d, expected 0", first); end
        checks++; if (got != 300) begin errors++; $display("FAIL basic_count: got %0d, expected 300", got); end
    endtask

    task automatic test_rate();
        int got = 0;
        do_reset();
        configure(16'h0100, 8'd3);
        push_samples(5);
        start_run();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rate_busy: got %b, expected 1", bus.busy); end
        for (int k = 1; k <= 20; k++) begin
            tick_obs();
            checks++;
            if (bus.out_valid !== ((k % 4) == 0)) begin
                errors++; $display("FAIL rate_valid[%0d]: got %b, expected %b", k, bus.out_valid, ((k % 4) == 0));
            end
            if (bus.out_valid && sb.size() > 0) begin
                exp_v = sb.pop_front();
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL rate_sample[%0d]: got %h, expected %h", got, obs_v, exp_v); end
                got++;
            end
        end
        checks++; if (got != 5) begin errors++; $display("FAIL rate_count: got %0d, expected 5", got); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        int held = 0;
        logic [5:0] held_addr = 0;
        do_reset();
        configure(16'h0100, 8'd0);
        push_samples(30);
        start_run();
        for (int cyc = 0; cyc < 80 && got < 30; cyc++) begin
            tick_obs();
            if (got == 5 && held < 10) begin
                bus.out_ready = 0;
                checks++;
                if (!bus.out_valid || (held > 0 && bus.lut_addr !== held_addr)) begin
                    errors++; $display("FAIL bp_hold[%0d]: got valid %b addr %0d, expected valid 1 addr %0d", held, bus.out_valid, bus.lut_addr, held_addr);
                end
                if (held == 0) held_addr = bus.lut_addr;
                held++;
            end else begin
                bus.out_ready = 1;
                if (bus.out_valid) begin
                    exp_v = sb.pop_front();
                    checks++;
                    if (obs_v !== exp_v) begin errors++; $display("FAIL bp_sample[%0d]: got %h, expected %h", got, obs_v, exp_v); end
                    got++;
                end
            end
        end
        bus.out_ready = 1;
        checks++; if (got != 30) begin errors++; $display("FAIL bp_count: got %0d, expected 30", got); end
    endtask

    task automatic test_cfg_in_run();
        int got = 0;
        do_reset();
        configure(16'h0100, 8'd3);
        push_samples(3);          // last of these coincides with the reload
        m_step = 16'h0400;
        push_samples(3);
        start_run();
        for (int k = 1; k <= 24; k++) begin
            tick_obs();
            bus.cfg_valid = 0;
            if (k == 11) begin
                checks++;
                if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_run: got %b, expected 1", bus.cfg_ready); end
                bus.cfg_valid = 1; bus.cfg_step = 16'h0400; bus.cfg_div = 8'd3;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL cfg_extra: got sample %h, expected none", obs_v);
                end else begin
                    exp_v = sb.pop_front();
                    checks++;
                    if (obs_v !== exp_v) begin errors++; $display("FAIL cfg_sample[%0d]: got %h, expected %h", got, obs_v, exp_v); end
                    got++;
                end
            end
        end
        checks++; if (got != 6) begin errors++; $display("FAIL cfg_count: got %0d, expected 6", got); end
    endtask

    task automatic test_stop();
        int got = 0;
        do_reset();
        configure(16'h0100, 8'(STOP_DIV));
        push_samples(STOP_TOTAL);
        start_run();
        for (int cyc = 0; cyc < STOP_TOTAL * (STOP_DIV + 1) + 40; cyc++) begin
            tick_obs();
            bus.stop = 0;
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL stop_extra: got sample %h, expected none", obs_v);
                end else begin
                    exp_v = sb.pop_front();
                    checks++;
                    if (obs_v !== exp_v) begin errors++; $display("FAIL stop_sample[%0d]: got %h, expected %h", got, obs_v, exp_v); end
                    got++;
                    if (got == STOP_AT) bus.stop = 1;
                end
            end
        end
        checks++; if (got != STOP_TOTAL) begin errors++; $display("FAIL stop_count: got %0d, expected %0d", got, STOP_TOTAL); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b, expected 0", bus.busy); end
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_cfg_ready: got %b, expected 1", bus.cfg_ready); end
    endtask

    task automatic test_step0_stop();
        int got = 0;
        bit sent = 0;
        do_reset();
        configure(16'h0000, 8'd0);
        push_samples(20);
        start_run();
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick_obs();
            bus.stop = 0;
            if (bus.out_valid) begin
                exp_v = sb.pop_front();
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL step0_sample[%0d]: got %h, expected %h", got, obs_v, exp_v); end
                got++;
                if (got == 3 && !sent) begin bus.stop = 1; sent = 1; end
            end
        end
        checks++; if (got != STEP0_TOTAL) begin errors++; $display("FAIL step0_count: got %0d, expected %0d", got, STEP0_TOTAL); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL step0_busy: got %b, expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        do_reset();
        configure(16'h0100, 8'd0);
        bus.out_ready = 0;
        start_run();
        tick_obs(); tick_obs();
        bus.stop = 1;
        tick_obs();
        bus.stop = 0;
        tick_obs();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b, expected 1", bus.out_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, expected 1", bus.busy); end
        checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_cfg_ready: got %b, expected 0", bus.cfg_ready); end
        rst = 1;
        tick_obs();
        checks++;
        if ({obs_v, bus.out_valid, bus.busy, bus.cfg_ready} !== 13'b0_0000_0000_0001) begin
            errors++; $display("FAIL mid_reset_outputs: got %b, expected 0000000000001", {obs_v, bus.out_valid, bus.busy, bus.cfg_ready});
        end
        rst = 0;
        bus.out_ready = 1;
        tick_obs();
        sb.delete();
        m_phase = 0;
        configure(16'h0100, 8'd0);
        push_samples(3);
        start_run();
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            tick_obs();
            if (bus.out_valid) begin
                exp_v = sb.pop_front();
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL mid_restart[%0d]: got %h, expected %h", got, obs_v, exp_v); end
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL mid_restart_count: got %0d, expected 3", got); end
    endtask

    initial begin
        m_phase = 0;
        m_step  = 0;
        test_reset();
        test_basic();
        test_rate();
        test_backpressure();
        test_cfg_in_run();
        test_stop();
        test_step0_stop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sine_sequencer.md
# sine_sequencer

Phase-accumulator controller that sequences the 64-entry quarter-wave sine LUT. It generates the mirrored LUT address and sign for each output sample at a programmable step and rate. It presents each sample to the DAC side over a valid/ready handshake, and stops gracefully at a period boundary. It sits between the configuration registers and the LUT/DAC datapath, replacing free-running address counting.

## Interface
- `ACC_W`, 16, phase accumulator width (≥ 8); `phase[ACC_W-1:ACC_W-2]` = quadrant, `phase[ACC_W-3:ACC_W-8]` = LUT index
- `DIV_W`, 8, sample-rate divider width
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — reset, synchronous, active-high
- `start` in 1 — start request, sampled in IDLE only
- `stop` in 1 — stop request, sampled in RUN only
- `cfg_valid` in 1 — configuration offered
- `cfg_ready` out 1 — configuration acceptable; high in IDLE and RUN
- `cfg_step` in ACC_W — phase increment per sample
- `cfg_div` in DIV_W — one sample every `cfg_div+1` cycles
- `lut_addr` out 6 — LUT address for the current sample
- `sign` out 1 — negative half-wave (quadrants 2, 3)
- `quadrant` out 2 — quadrant of the current sample
- `out_valid` out 1 — sample available
- `out_ready` in 1 — downstream accepts the sample
- `wrap` out 1 — one-cycle pulse on the last sample of a period
- `busy` out 1 — state ≠ IDLE

## Operation
- Registers:
  - `phase` (ACC_W)
  - `step` (ACC_W)
  - `div` (DIV_W)
  - `cnt` (DIV_W)
  - FSM state
- Configuration: a transfer occurs when `cfg_valid && cfg_ready`.
  - It loads `step` and `div` and clears `cnt`.
  - A tick in the same cycle uses the old values.
- Tick: `cnt == div` in RUN or STOPPING, and not (`out_valid && !out_ready`).
  - When a tick is blocked, `cnt` holds at `div`; no sample is ever dropped.
- On a tick:
  - `{quadrant, idx}` are taken from `phase`.
  - `lut_addr` ← `quadrant[0] ? ~idx : idx`.
  - `sign` ← `quadrant[1]`.
  - `out_valid` ← 1.
  - `phase` ← `phase + step`, modulo 2^ACC_W.
  - `wrap` ← carry-out of that addition.
  - `cnt` ← 0.
- Otherwise `cnt` increments.
- `out_valid` clears the cycle after `out_valid && out_ready`, unless a tick reloads it in that same cycle.
- FSM:
  - IDLE: on `start`, clear `phase` and `cnt` and go to RUN. `stop` is ignored.
  - RUN: on `stop`, go to STOPPING (see Configuration). `start` is ignored.
  - STOPPING: keep ticking. On the tick whose addition carries out, go to DRAIN. If `step == 0`, go to DRAIN immediately.
  - DRAIN: no ticks. When `out_valid` is low, or is accepted this cycle, go to IDLE and clear `phase`.
- `start` and `stop` in the same IDLE cycle: `start` wins.
- `stop` in STOPPING or DRAIN is ignored.
- `cfg_ready` is low in STOPPING and DRAIN.

## Timing
- Reset values:
  - Outputs: `lut_addr`=0, `sign`=0, `quadrant`=0, `out_valid`=0, `wrap`=0, `busy`=0, `cfg_ready`=1.
  - State = IDLE; `phase`, `step`, `div`, `cnt` all = 0.
- `rst` asserted mid-operation clears everything at the next edge, including a pending `out_valid`.
- `start` sampled at edge n:
  - `busy` is high after edge n.
  - The first `out_valid` is high after edge n+div+1, carrying phase 0 (addr 0, sign 0).
- Sample spacing is exactly `div+1` cycles while `out_ready` is held high.
  - `div=0` with `out_ready` high gives `out_valid` continuously high with a new sample every cycle.
- All outputs are registered; there are no combinational paths from input to output.
- `wrap` is high only in the first cycle of the flagged sample.

## Configuration
- `SINE_SEQ_STOP_ZC_EN` defined: `stop` moves RUN → STOPPING. The period completes and output ends on the last sample before the zero crossing.
- Undefined: `stop` moves RUN → DRAIN directly. No further ticks occur; any pending sample is still delivered, then the FSM goes to IDLE.

## Test plan
- Basic sequence: `step`=0x0100, `div`=0, `out_ready`=1, start. Required response:
  - `lut_addr` runs 0..63 (q0), 63..0 (q1), 0..63 with `sign`=1 (q2), 63..0 with `sign`=1 (q3).
  - `wrap` pulses on sample 256, then the sequence repeats.
- Rate: `div`=3, start at edge 10. Required: first `out_valid` after edge 14, then one sample every 4 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles at `div`=0. Required:
  - `out_valid` stays high with a stable `lut_addr`.
  - `phase` is frozen; no sample is lost after release.
- Graceful stop (macro on): `stop` at sample 100. Required:
  - Output continues to sample 256 (addr 0, sign 1, `wrap`=1).
  - The FSM goes to IDLE after acceptance, with `busy`=0. With `step`=0, stop goes to IDLE after one drain.
- Immediate stop (macro off), plus config in RUN: stop at sample 5 gives no sample 6 and `busy`=0 after drain.
  - A `cfg_valid` coincident with a tick gives old-step addressing for that tick and the new step on the next.
- Reset during STOPPING with `out_valid`=1: all outputs are 0 after the next edge; a subsequent `start` restarts at addr 0.
